// File: rtl/nios_frame_pkg.sv
// rtl/nios_frame_pkg.sv - shared types and helpers for the Nios frame writer
package nios_frame_pkg;

  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = PIX_W * LANES;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOP,
    CAPTURE,
    DONE
  } frame_state_e;

  // Byte lanes 0..lane are valid in a word closed at 'lane'.
  function automatic logic [LANES-1:0] be_for_lane(input logic [1:0] lane);
    logic [LANES-1:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0011;
      2'd2:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/nios_pixel_packer.sv
// rtl/nios_pixel_packer.sv - packs 8-bit pixels into 32-bit words with pending/final handshake
module nios_pixel_packer
  import nios_frame_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hunting,
  input  logic              active,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  input  logic              pop,
  output logic              pending,
  output logic              final_word,
  output logic [WORD_W-1:0] word_data,
  output logic [LANES-1:0]  word_be,
  output logic              frame_start,
  output logic              sop_restart
);

  logic [1:0]        cnt;
  logic [WORD_W-1:0] lane_buf;
  logic [WORD_W-1:0] merged;
  logic [1:0]        lane_sel;
  logic              beat;
  logic              take;

  // A slot frees up in the same cycle the pending word leaves.
  assign in_ready    = active && !final_word && (!pending || pop);
  assign beat        = in_valid && in_ready;
  assign take        = beat && (!hunting || in_sop);
  assign frame_start = beat && in_sop && hunting;
  assign sop_restart = beat && in_sop && !hunting;

  // sop always lands in lane 0, discarding any partial word.
  assign lane_sel = in_sop ? 2'd0 : cnt;

  always_comb begin
    merged = in_sop ? '0 : lane_buf;
    merged[{lane_sel, 3'b000} +: PIX_W] = in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 2'd0;
      lane_buf   <= '0;
      pending    <= 1'b0;
      final_word <= 1'b0;
      word_data  <= '0;
      word_be    <= '0;
    end else if (clear) begin
      cnt        <= 2'd0;
      lane_buf   <= '0;
      pending    <= 1'b0;
      final_word <= 1'b0;
    end else begin
      if (pop) begin
        pending <= 1'b0;
      end
      if (take) begin
        if (lane_sel == 2'd3 || in_eop) begin
          pending    <= 1'b1;
          word_data  <= merged;
          word_be    <= be_for_lane(lane_sel);
          cnt        <= 2'd0;
          lane_buf   <= '0;
          final_word <= in_eop;
        end else begin
          lane_buf <= merged;
          cnt      <= lane_sel + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/nios_frame_writer.sv
// rtl/nios_frame_writer.sv - writes a packed grayscale frame into the Nios frame memory
module nios_frame_writer
  import nios_frame_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int BASE_WORD = 0,
  parameter int MAX_WORDS = 5120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   frame_words,
  output logic              err_overflow,
  output logic              err_sop
);

  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_WORD);

  frame_state_e      state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W-1:0] addr_q;
  logic              pending;
  logic              final_word;
  logic              frame_start;
  logic              sop_restart;
  logic              at_limit;
  logic              pop;
  logic              wr;
  logic              start_ok;
  logic              hunting;
  logic              active;

  assign hunting  = (state == WAIT_SOP);
  assign active   = (state == WAIT_SOP) || (state == CAPTURE);
  assign busy     = active;
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Past capacity the word is retired without touching memory.
  assign at_limit = (ptr == LIMIT);
  assign pop      = pending && (mem_grant || at_limit);
  assign wr       = pending && mem_grant && !at_limit;

  assign mem_chipselect = wr;
  assign mem_write      = wr;
  assign mem_address    = addr_q;

  nios_pixel_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (start_ok),
    .hunting     (hunting),
    .active      (active),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_ready    (in_ready),
    .pop         (pop),
    .pending     (pending),
    .final_word  (final_word),
    .word_data   (mem_writedata),
    .word_be     (mem_byteenable),
    .frame_start (frame_start),
    .sop_restart (sop_restart)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      addr_q       <= '0;
      frame_words  <= '0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      err_sop      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= WAIT_SOP;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_sop      <= 1'b0;
          end
        end
        WAIT_SOP: begin
          if (frame_start) state <= CAPTURE;
        end
        CAPTURE: begin
          if (pop && final_word) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A restart still lets a full pending word go out at the old address.
      if (start_ok || sop_restart) begin
        ptr         <= '0;
        addr_q      <= BASE;
        frame_words <= '0;
      end else if (wr) begin
        ptr         <= ptr + 1'b1;
        addr_q      <= addr_q + 1'b1;
        frame_words <= frame_words + 1'b1;
      end

      if (sop_restart) err_sop <= 1'b1;
      if (pop && at_limit) err_overflow <= 1'b1;
    end
  end

endmodule
